// File: rtl/vx_decode_ibuf_pkg.sv
// -----------------------------------------------------------------------------
// vx_decode_ibuf_pkg
// Shared definitions for the decode-to-issue instruction buffer.
//   - Default configuration constants and the values derived from them
//     (WARPS_PER_SLOT, CNT_WIDTH).
//   - ibuf_entry_t: packed {wid, data} record for the default configuration.
//   - slot_of(): maps a warp id onto the issue slot that serves it.
// -----------------------------------------------------------------------------
package vx_decode_ibuf_pkg;

    localparam int DEF_NUM_WARPS   = 4;
    localparam int DEF_ISSUE_WIDTH = 2;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_WID_WIDTH   = $clog2(DEF_NUM_WARPS);

    localparam int WARPS_PER_SLOT  = DEF_NUM_WARPS / DEF_ISSUE_WIDTH;
    localparam int CNT_WIDTH       = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_WID_WIDTH-1:0]  wid;
        logic [DEF_DATA_WIDTH-1:0] data;
    } ibuf_entry_t;

    // Warp w is always served by slot w % issue_width.
    function automatic int unsigned slot_of(input int unsigned wid,
                                            input int unsigned issue_width = DEF_ISSUE_WIDTH);
        return wid % issue_width;
    endfunction

endpackage

// File: rtl/vx_ibuf_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vx_ibuf_rr_arbiter
// N-request round-robin arbiter with hold-on-stall.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector (local warp indices of one slot)
//   hold       : current grant is valid but not accepted; freeze it
//   advance    : current grant is accepted; move priority past it
//   valid      : any request present
//   grant      : granted local index (combinational)
// -----------------------------------------------------------------------------
module vx_ibuf_rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             hold,
    input  logic             advance,
    output logic             valid,
    output logic [IDX_W-1:0] grant
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] hold_idx;
    logic             hold_r;
    logic [IDX_W-1:0] raw_grant;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester at or
    // after rr_ptr is the one that survives.
    always_comb begin
        raw_grant = rr_ptr;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand      = IDX_W'((32'(rr_ptr) + 32'(k)) % 32'(N));
            raw_grant = req[cand] ? cand : raw_grant;
        end
    end

    assign valid = |req;
    // A stalled grant must not move when a higher-priority warp fills up.
    assign grant = hold_r ? hold_idx : raw_grant;

    // Priority pointer and stall latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            hold_r   <= 1'b0;
            hold_idx <= '0;
        end else if (advance) begin
            rr_ptr   <= (32'(grant) == 32'(N - 1)) ? '0 : grant + IDX_W'(1);
            hold_r   <= 1'b0;
        end else begin
            hold_r   <= hold;
            hold_idx <= grant;
        end
    end

endmodule

// File: rtl/vx_decode_ibuf.sv
// -----------------------------------------------------------------------------
// vx_decode_ibuf
// Decode-to-issue instruction buffer: one per-warp FIFO per warp, drained onto
// ISSUE_WIDTH issue slots; warp w is served by slot w % ISSUE_WIDTH through a
// round-robin arbiter per slot.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : decoded-instruction handshake (in_ready depends only
//                       on in_wid occupancy, never on in_valid)
//   in_wid, in_data   : warp id and payload of the incoming instruction
//   out_valid/ready   : per-slot issue handshake
//   out_wid, out_data : per-slot granted warp id and head payload
//   ibuf_pop          : per-slot dequeue pulse, same cycle as the fire
//
// Build option
//   VX_DECODE_IBUF_BYPASS_EN : an instruction for an empty warp whose slot is
//   idle and ready passes straight to out_* in the same cycle without being
//   written to the FIFO. Undefined by default (minimum latency 1 cycle).
// -----------------------------------------------------------------------------
module vx_decode_ibuf
    import vx_decode_ibuf_pkg::*;
#(
    parameter int NUM_WARPS   = DEF_NUM_WARPS,
    parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WID_WIDTH   = $clog2(NUM_WARPS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [WID_WIDTH-1:0]            in_wid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic [ISSUE_WIDTH-1:0]          out_valid,
    output logic [ISSUE_WIDTH*WID_WIDTH-1:0]  out_wid,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_data,
    input  logic [ISSUE_WIDTH-1:0]          out_ready,
    output logic [ISSUE_WIDTH-1:0]          ibuf_pop
);

    localparam int WPS    = NUM_WARPS / ISSUE_WIDTH;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LIDX_W = (WPS > 1) ? $clog2(WPS) : 1;

    logic [DATA_WIDTH-1:0] mem   [NUM_WARPS][DEPTH];
    logic [CNT_W-1:0]      count [NUM_WARPS];
    logic [PTR_W-1:0]      rptr  [NUM_WARPS];
    logic [PTR_W-1:0]      wptr  [NUM_WARPS];

    logic [NUM_WARPS-1:0]   push_w;
    logic [NUM_WARPS-1:0]   pop_w;
    logic [ISSUE_WIDTH-1:0] bypass;
    logic [ISSUE_WIDTH-1:0] fire;
    logic                   push;

    // A full queue refuses even when it pops this cycle.
    assign in_ready = (count[in_wid] != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !(|bypass);

    // One-hot push target.
    always_comb begin
        push_w = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_w[w] = push && (in_wid == WID_WIDTH'(w));
        end
    end

    // Pointer and occupancy bookkeeping for every warp FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count[w] <= '0;
                rptr[w]  <= '0;
                wptr[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wptr[w]  <= wptr[w] + PTR_W'(push_w[w]);
                rptr[w]  <= rptr[w] + PTR_W'(pop_w[w]);
                count[w] <= count[w] + CNT_W'(push_w[w]) - CNT_W'(pop_w[w]);
            end
        end
    end

    // Payload storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[in_wid][wptr[in_wid]] <= in_data;
        end
    end

    for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
        logic [WPS-1:0]       req;
        logic [WPS-1:0]       req_eff;
        logic [LIDX_W-1:0]    grant;
        logic [WID_WIDTH-1:0] gwid;
        logic                 arb_valid;
        logic                 byp;

        // Non-empty warps served by this slot, by local index.
        always_comb begin
            req = '0;
            for (int l = 0; l < WPS; l++) begin
                req[l] = (count[l * ISSUE_WIDTH + s] != '0);
            end
        end

`ifdef VX_DECODE_IBUF_BYPASS_EN
        // The slot being idle implies the target warp's queue is empty too.
        assign byp = in_valid && !reset && out_ready[s] && (req == '0) &&
                     (slot_of(32'(in_wid), ISSUE_WIDTH) == 32'(s));
`else
        assign byp = 1'b0;
`endif
        assign bypass[s] = byp;

        // A bypassed instruction appears as a request so the pointer update
        // is identical to a normal pop.
        always_comb begin
            req_eff = '0;
            for (int l = 0; l < WPS; l++) begin
                req_eff[l] = req[l] || (byp && (32'(in_wid) == 32'(l * ISSUE_WIDTH + s)));
            end
        end

        vx_ibuf_rr_arbiter #(
            .N(WPS)
        ) u_arb (
            .clk     (clk),
            .reset   (reset),
            .req     (req_eff),
            .hold    (out_valid[s] && !out_ready[s]),
            .advance (fire[s]),
            .valid   (arb_valid),
            .grant   (grant)
        );

        assign gwid         = WID_WIDTH'(32'(grant) * 32'(ISSUE_WIDTH) + 32'(s));
        assign out_valid[s] = arb_valid && !reset;
        assign fire[s]      = out_valid[s] && out_ready[s];
        assign ibuf_pop[s]  = fire[s];
        assign out_wid[s*WID_WIDTH +: WID_WIDTH]    = byp ? in_wid  : gwid;
        assign out_data[s*DATA_WIDTH +: DATA_WIDTH] = byp ? in_data : mem[gwid][rptr[gwid]];

        for (genvar l = 0; l < WPS; l++) begin : g_pop
            assign pop_w[l * ISSUE_WIDTH + s] = fire[s] && !byp && (grant == LIDX_W'(l));
        end
    end

endmodule
